eth_rx_packer: RTL

- MII receive front end for the DELQA receive path.
- Runs in the Ethernet receive clock domain. Strips preamble/SFD, assembles nibbles into bytes and bytes into 16-bit words, checks FCS, and writes the frame into the Ethernet port of the RX buffer.
- Presents a per-frame status (length, error flags) to the firmware-side handshake.
- Single-buffer discipline: the block is armed, receives one frame, then holds until acknowledged.

---
 rtl/eth_rx_packer.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_packer.sv
// eth_rx_packer: MII receive front end for the DELQA receive path.
// Strips preamble/SFD, packs nibbles into bytes and bytes into 16-bit words,
// checks the FCS and writes the frame into the RX buffer, then presents a
// per-frame status and holds until the firmware acknowledges it.
//
// Ports:
//   eth_clk_i    MII RX clock (only clock)
//   eth_rst_i    synchronous reset, active-high
//   mii_rxd_i    receive nibble, low nibble of each byte first
//   mii_rxdv_i   receive data valid
//   mii_rxer_i   receive error
//   rx_ena_i     firmware arm, sampled at SFD
//   rx_ack_i     firmware acknowledge of rx_rdy_o
//   eth_adr_o    RX buffer word address
//   eth_dat_o    RX buffer write data (byte n low, byte n+1 high)
//   eth_we_o     RX buffer write enable, one cycle per word
//   rx_rdy_o     frame complete, status valid
//   rx_len_o     stored byte count, FCS included
//   rx_crcerr_o  FCS mismatch
//   rx_phyerr_o  mii_rxer_i seen during the frame
//   rx_long_o    frame exceeded MAXLEN
//   rx_runt_o    frame shorter than MINLEN
//   rx_align_o   odd nibble count at end of frame
//   rx_miss_o    saturating count of frames missed while unarmed or busy
//
// MAXLEN must not exceed 2046 so the 10-bit word pointer never wraps.

module eth_rx_packer #(
   parameter int unsigned MAXLEN = 1518,
   parameter int unsigned MINLEN = 64
) (
   input  logic        eth_clk_i,
   input  logic        eth_rst_i,
   input  logic [3:0]  mii_rxd_i,
   input  logic        mii_rxdv_i,
   input  logic        mii_rxer_i,
   input  logic        rx_ena_i,
   input  logic        rx_ack_i,
   output logic [9:0]  eth_adr_o,
   output logic [15:0] eth_dat_o,
   output logic        eth_we_o,
   output logic        rx_rdy_o,
   output logic [10:0] rx_len_o,
   output logic        rx_crcerr_o,
   output logic        rx_phyerr_o,
   output logic        rx_long_o,
   output logic        rx_runt_o,
   output logic        rx_align_o,
   output logic [7:0]  rx_miss_o
);

   localparam int unsigned LEN_W  = 11;
   localparam int unsigned ADR_W  = 10;
   localparam int unsigned DAT_W  = 16;
   localparam int unsigned MISS_W = 8;

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   localparam logic [3:0] NIB_PRE = 4'h5;
   localparam logic [3:0] NIB_SFD = 4'hD;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_FLUSH,
      S_STAT,
      S_HOLD,
      S_DROP
   } state_t;

   // Reflected CRC-32 advanced by one nibble, LSB first.
   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 4; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
         else             r = r >> 1;
      end
      return r;
   endfunction

   state_t              r_state;
   logic [ADR_W-1:0]    r_ptr;
   logic [LEN_W-1:0]    r_cnt;
   logic [31:0]         r_crc;
   logic                r_nib_odd;
   logic [3:0]          r_lo_nib;
   logic                r_byte_hi;
   logic [7:0]          r_lo_byte;
   logic                r_long;
   logic                r_phy;
   logic                r_align;
   logic                r_prev5;
   logic                r_sh_seen;
   logic                r_wait;

   logic [ADR_W-1:0]    r_adr;
   logic [DAT_W-1:0]    r_dat;
   logic                r_we;
   logic                r_rdy;
   logic [LEN_W-1:0]    r_len;
   logic                r_crcerr;
   logic                r_phyerr;
   logic                r_long_q;
   logic                r_runt;
   logic                r_align_q;
   logic [MISS_W-1:0]   r_miss;

   logic                w_sfd;
   logic [7:0]          w_byte;
   logic                w_room;
   logic [MISS_W-1:0]   w_miss_nxt;

   // SFD is the nibble D directly after a preamble nibble 5.
   assign w_sfd      = mii_rxdv_i && (mii_rxd_i == NIB_SFD) && r_prev5;
   assign w_byte     = {mii_rxd_i, r_lo_nib};
   assign w_room     = r_cnt < LEN_W'(MAXLEN);
   assign w_miss_nxt = (r_miss == {MISS_W{1'b1}}) ? r_miss : r_miss + MISS_W'(1);

   // Receive state machine, buffer writer and status registers.
   always_ff @(posedge eth_clk_i) begin
      if (eth_rst_i) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_crc     <= CRC_INIT;
         r_nib_odd <= 1'b0;
         r_lo_nib  <= '0;
         r_byte_hi <= 1'b0;
         r_lo_byte <= '0;
         r_long    <= 1'b0;
         r_phy     <= 1'b0;
         r_align   <= 1'b0;
         r_prev5   <= 1'b0;
         r_sh_seen <= 1'b0;
         // A frame in flight at reset is ignored until its carrier drops.
         r_wait    <= 1'b1;
         r_adr     <= '0;
         r_dat     <= '0;
         r_we      <= 1'b0;
         r_rdy     <= 1'b0;
         r_len     <= '0;
         r_crcerr  <= 1'b0;
         r_phyerr  <= 1'b0;
         r_long_q  <= 1'b0;
         r_runt    <= 1'b0;
         r_align_q <= 1'b0;
         r_miss    <= '0;
      end else begin
         r_we      <= 1'b0;
         r_prev5   <= mii_rxdv_i && (mii_rxd_i == NIB_PRE);
         r_wait    <= r_wait && mii_rxdv_i;
         r_sh_seen <= r_sh_seen && mii_rxdv_i;

         case (r_state)
            S_IDLE: begin
               if (mii_rxdv_i && !r_wait) r_state <= S_PRE;
            end

            S_PRE: begin
               if (!mii_rxdv_i) begin
                  r_state <= S_IDLE;
               end else if (w_sfd) begin
                  if (rx_ena_i) begin
                     r_state   <= S_DATA;
                     r_ptr     <= '0;
                     r_cnt     <= '0;
                     r_crc     <= CRC_INIT;
                     r_nib_odd <= 1'b0;
                     r_byte_hi <= 1'b0;
                     r_long    <= 1'b0;
                     r_phy     <= 1'b0;
                     r_align   <= 1'b0;
                  end else begin
                     r_state <= S_DROP;
                     r_miss  <= w_miss_nxt;
                  end
               end
            end

            S_DATA: begin
               if (mii_rxer_i) r_phy <= 1'b1;
               if (!mii_rxdv_i) begin
                  r_state <= S_FLUSH;
               end else begin
                  r_crc     <= crc_nib(r_crc, mii_rxd_i);
                  r_nib_odd <= ~r_nib_odd;
                  if (!r_nib_odd) begin
                     r_lo_nib <= mii_rxd_i;
                  end else if (w_room) begin
                     r_cnt <= r_cnt + LEN_W'(1);
                     if (!r_byte_hi) begin
                        r_lo_byte <= w_byte;
                        r_byte_hi <= 1'b1;
                     end else begin
                        r_we      <= 1'b1;
                        r_adr     <= r_ptr;
                        r_dat     <= {w_byte, r_lo_byte};
                        r_ptr     <= r_ptr + ADR_W'(1);
                        r_byte_hi <= 1'b0;
                     end
                  end else begin
                     // Over-length bytes still feed the CRC but are not stored.
                     r_long <= 1'b1;
                  end
               end
            end

            S_FLUSH: begin
               if (r_byte_hi) begin
                  r_we      <= 1'b1;
                  r_adr     <= r_ptr;
                  r_dat     <= {8'h00, r_lo_byte};
                  r_ptr     <= r_ptr + ADR_W'(1);
                  r_byte_hi <= 1'b0;
               end
               r_align <= r_nib_odd;
               r_state <= S_STAT;
            end

            S_STAT: begin
               r_len     <= r_cnt;
               r_crcerr  <= (r_crc != CRC_RESIDUE);
               r_phyerr  <= r_phy;
               r_long_q  <= r_long;
               r_runt    <= (r_cnt < LEN_W'(MINLEN));
               r_align_q <= r_align;
               r_rdy     <= 1'b1;
               r_sh_seen <= 1'b0;
               r_state   <= S_HOLD;
            end

            S_HOLD: begin
               // Shadow preamble detector: count one miss per carrier with SFD.
               if (w_sfd && !r_sh_seen) begin
                  r_miss    <= w_miss_nxt;
                  r_sh_seen <= 1'b1;
               end
               if (rx_ack_i) begin
                  r_rdy   <= 1'b0;
                  r_state <= S_IDLE;
                  r_wait  <= mii_rxdv_i;
               end
            end

            S_DROP: begin
               if (!mii_rxdv_i) r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign eth_adr_o   = r_adr;
   assign eth_dat_o   = r_dat;
   assign eth_we_o    = r_we;
   assign rx_rdy_o    = r_rdy;
   assign rx_len_o    = r_len;
   assign rx_crcerr_o = r_crcerr;
   assign rx_phyerr_o = r_phyerr;
   assign rx_long_o   = r_long_q;
   assign rx_runt_o   = r_runt;
   assign rx_align_o  = r_align_q;
   assign rx_miss_o   = r_miss;

endmodule
